// File: rtl/ntt_layer_ctrl_if.sv
// Bundle of everything the NTT layer controller exchanges with the request side,
// the coefficient RAM, the twiddle ROM and the butterfly unit.
interface ntt_layer_ctrl_if #(
  parameter int DATA_WIDTH = 13
);
  localparam int CW = DATA_WIDTH - 1;

  // layer request / status
  logic                  start_i;
  logic [2:0]            span_log2_i;
  logic                  is_ntt_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;

  // coefficient RAM read side and twiddle ROM
  logic [7:0]            rd_addr_a_o;
  logic [7:0]            rd_addr_b_o;
  logic [CW-1:0]         rd_data_a_i;
  logic [CW-1:0]         rd_data_b_i;
  logic [6:0]            zeta_addr_o;
  logic [CW-1:0]         zeta_i;

  // butterfly operands and results
  logic [DATA_WIDTH-1:0] bu_a_o;
  logic [DATA_WIDTH-1:0] bu_b_o;
  logic [CW-1:0]         bu_zeta_o;
  logic                  bu_is_ntt_o;
  logic [CW-1:0]         bu_a_ntt_i;
  logic [CW-1:0]         bu_b_ntt_i;
  logic [CW-1:0]         bu_a_intt_i;
  logic [CW-1:0]         bu_b_intt_i;

  // coefficient RAM write side
  logic                  wr_en_o;
  logic [7:0]            wr_addr_a_o;
  logic [7:0]            wr_addr_b_o;
  logic [CW-1:0]         wr_data_a_o;
  logic [CW-1:0]         wr_data_b_o;

  // controller side
  modport master (
    input  start_i, span_log2_i, is_ntt_i,
    output busy_o, done_o, error_o,
    output rd_addr_a_o, rd_addr_b_o,
    input  rd_data_a_i, rd_data_b_i,
    output zeta_addr_o,
    input  zeta_i,
    output bu_a_o, bu_b_o, bu_zeta_o, bu_is_ntt_o,
    input  bu_a_ntt_i, bu_b_ntt_i, bu_a_intt_i, bu_b_intt_i,
    output wr_en_o, wr_addr_a_o, wr_addr_b_o, wr_data_a_o, wr_data_b_o
  );

  // requester / memories / butterfly side
  modport slave (
    output start_i, span_log2_i, is_ntt_i,
    input  busy_o, done_o, error_o,
    input  rd_addr_a_o, rd_addr_b_o,
    output rd_data_a_i, rd_data_b_i,
    input  zeta_addr_o,
    output zeta_i,
    input  bu_a_o, bu_b_o, bu_zeta_o, bu_is_ntt_o,
    output bu_a_ntt_i, bu_b_ntt_i, bu_a_intt_i, bu_b_intt_i,
    input  wr_en_o, wr_addr_a_o, wr_addr_b_o, wr_data_a_o, wr_data_b_o
  );
endinterface

// File: rtl/ntt_layer_ctrl.sv
// Sequences one NTT/iNTT layer: 128 butterflies issued back to back, operands read
// from RAM, results written back BU_LAT+2 cycles after issue, then a done pulse.
module ntt_layer_ctrl #(
  parameter int DATA_WIDTH = 13,
  parameter int BU_LAT     = 6
) (
  input  logic           clk_i,
  input  logic           rst_i,
  ntt_layer_ctrl_if.master bus
);
  localparam int CW     = DATA_WIDTH - 1;
  // stage 0 = registered read address, stage 1 = read data at butterfly,
  // stage STAGES = butterfly result at write port
  localparam int STAGES = BU_LAT + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } addr_pair_t;

  state_t          state;
  logic [6:0]      k_q;
  logic [2:0]      span_q;
  logic            mode_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;
  logic [6:0]      zeta_addr_q;
  logic [STAGES:0] vld_pipe;
  addr_pair_t      addr_pipe [STAGES:0];

  // issue address generation for butterfly k_q at the latched span
  logic [3:0] sh1_c;
  logic [7:0] h_c, g_c, j_c, a_c, b_c;
  logic [6:0] zeta_c;

  always_comb begin
    sh1_c  = {1'b0, span_q} + 4'd1;
    h_c    = 8'd1 << span_q;
    g_c    = {1'b0, k_q} >> span_q;
    j_c    = {1'b0, k_q} & (h_c - 8'd1);
    a_c    = (g_c << sh1_c) | j_c;
    b_c    = a_c + h_c;
    // NTT walks zetas forward from 128>>span, iNTT walks backwards from the top
    zeta_c = mode_q ? 7'((8'd128 >> span_q) + g_c)
                    : 7'((9'd256 >> span_q) - 9'd1 - {1'b0, g_c});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      k_q         <= '0;
      span_q      <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      zeta_addr_q <= '0;
      vld_pipe    <= '0;
      for (int i = 0; i <= STAGES; i++) addr_pipe[i] <= '0;
    end else begin
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      vld_pipe    <= {vld_pipe[STAGES-1:0], 1'b0};
      addr_pipe[0] <= '0;
      for (int i = 1; i <= STAGES; i++) addr_pipe[i] <= addr_pipe[i-1];
      zeta_addr_q <= '0;

      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.span_log2_i != 3'd0) begin
              span_q <= bus.span_log2_i;
              mode_q <= bus.is_ntt_i;
              k_q    <= '0;
              busy_q <= 1'b1;
              state  <= S_ISSUE;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          vld_pipe[0]  <= 1'b1;
          addr_pipe[0] <= '{a: a_c, b: b_c};
          zeta_addr_q  <= zeta_c;
          k_q          <= k_q + 7'd1;
          if (k_q == 7'd127) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // the pipe holds one contiguous run, so this is its tail at the write port
          if (vld_pipe[STAGES] && !vld_pipe[STAGES-1]) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          span_q <= '0;
          mode_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.error_o     = error_q;
  assign bus.rd_addr_a_o = addr_pipe[0].a;
  assign bus.rd_addr_b_o = addr_pipe[0].b;
  assign bus.zeta_addr_o = zeta_addr_q;

  // operands are forced to zero whenever the RAM output is not a live read
  assign bus.bu_a_o      = vld_pipe[1] ? {1'b0, bus.rd_data_a_i} : '0;
  assign bus.bu_b_o      = vld_pipe[1] ? {1'b0, bus.rd_data_b_i} : '0;
  assign bus.bu_zeta_o   = vld_pipe[1] ? bus.zeta_i : '0;
  assign bus.bu_is_ntt_o = mode_q;

  assign bus.wr_en_o     = vld_pipe[STAGES];
  assign bus.wr_addr_a_o = vld_pipe[STAGES] ? addr_pipe[STAGES].a : '0;
  assign bus.wr_addr_b_o = vld_pipe[STAGES] ? addr_pipe[STAGES].b : '0;
  assign bus.wr_data_a_o = !vld_pipe[STAGES] ? CW'(0) :
                           (mode_q ? bus.bu_a_ntt_i : bus.bu_a_intt_i);
  assign bus.wr_data_b_o = !vld_pipe[STAGES] ? CW'(0) :
                           (mode_q ? bus.bu_b_ntt_i : bus.bu_b_intt_i);
endmodule

// File: doc/ntt_layer_ctrl.md
NTT_LAYER_CTRL -- requirements
Module: ntt_layer_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 13: butterfly operand width; coefficients are DATA_WIDTH-1 bits.
REQ-002 SHALL have parameter BU_LAT, default 6: cycles from the butterfly input-sample edge to its registered outputs.
REQ-003 SHALL have clk_i  in  1  sole clock, rising edge.
REQ-004 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have start_i  in  1  request one layer; span_log2_i  in  3  log2 of half-span h (legal 1..7); is_ntt_i  in  1  1=NTT, 0=iNTT.
REQ-006 SHALL have busy_o  out  1; done_o  out  1  one-cycle pulse; error_o  out  1  one-cycle pulse.
REQ-007 SHALL have rd_addr_a_o, rd_addr_b_o  out  8; rd_data_a_i, rd_data_b_i  in  DATA_WIDTH-1  coefficient RAM read data, 1-cycle read latency.
REQ-008 SHALL have zeta_addr_o  out  7; zeta_i  in  DATA_WIDTH-1  twiddle ROM data, 1-cycle latency.
REQ-009 SHALL have bu_a_o, bu_b_o  out  DATA_WIDTH; bu_zeta_o  out  DATA_WIDTH-1; bu_is_ntt_o  out  1.
REQ-010 SHALL have bu_a_ntt_i, bu_b_ntt_i, bu_a_intt_i, bu_b_intt_i  in  DATA_WIDTH-1  butterfly results.
REQ-011 SHALL have wr_en_o  out  1; wr_addr_a_o, wr_addr_b_o  out  8; wr_data_a_o, wr_data_b_o  out  DATA_WIDTH-1  coefficient RAM write port.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-013 SHALL, in IDLE with start_i=1 and span_log2_i in 1..7, latch span and mode and enter ISSUE ("accept edge").
REQ-014 SHALL, in IDLE with start_i=1 and span_log2_i of 0, leave state at IDLE and pulse error_o the next cycle.
REQ-015 SHALL ignore start_i outside IDLE, including the DONE cycle.
REQ-016 SHALL issue butterfly k=0..127 in cycle k+1 after the accept edge, one per cycle, no stalls.
REQ-017 SHALL compute g=k>>span, j=k&(h-1), rd_addr_a_o=g*2h+j, rd_addr_b_o=rd_addr_a_o+h, all as registered outputs.
REQ-018 SHALL drive zeta_addr_o=(128>>span)+g for NTT and (256>>span)-1-g for iNTT, same cycle as read addresses.
REQ-019 SHALL drive bu_a_o/bu_b_o as zero-extended rd_data one cycle after issue, bu_zeta_o=zeta_i, bu_is_ntt_o=latched mode; bu_a_o/bu_b_o/bu_zeta_o SHALL be 0 in any cycle without valid read data.
REQ-020 SHALL carry valid, addr_a and addr_b through a shift pipeline so butterfly k writes in cycle k+2+BU_LAT after the accept edge.
REQ-021 SHALL select write data from the *_ntt_i inputs when latched mode=NTT, else from the *_intt_i inputs; wr_en_o SHALL be 0 otherwise.
REQ-022 SHALL enter DRAIN after issue 127 and remain until the last write cycle, then DONE for exactly one cycle.
REQ-023 SHALL assert done_o only in DONE, cycle 130+BU_LAT after the accept edge.
REQ-024 SHALL hold busy_o=1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-025 SHALL perform no address-hazard checking, because each address is read and written exactly once per layer.

Reset
REQ-026 SHALL, with rst_i=1 at an edge, enter IDLE and clear every valid pipeline stage, including mid-ISSUE or mid-DRAIN; no wr_en_o SHALL follow.
REQ-027 SHALL hold all outputs at 0 while in reset and in IDLE, except rd/zeta addresses, which hold at 0.
REQ-028 SHALL accept a start on the first edge after rst_i deasserts.

Verification
REQ-029 SHALL cover reset: 3 cycles of rst_i -> every output 0, busy_o=0.
REQ-030 SHALL cover NTT span=7, BU_LAT=6:
- k=0 -> A=0, B=128, zeta 1
- k=127 -> A=127, B=255, zeta 1
- writes in cycles 8..135 carry bu_*_ntt_i with matching addresses
- done_o in cycle 136
REQ-031 SHALL cover iNTT span=1 -> issue order 0/2, 1/3, 4/6, 5/7; zeta 127,127,126,126; write data from bu_*_intt_i.
REQ-032 SHALL cover start while busy -> ignored; start with span=0 -> error_o pulse, busy_o stays 0.
REQ-033 SHALL cover rst_i at cycle 50 of ISSUE -> wr_en_o=0 from the next cycle, IDLE; a fresh start then completes with done_o at 136.
REQ-034 SHALL cover start_i held high -> second accept on the edge ending the first cycle after DONE, i.e. IDLE exactly one cycle.
